ir_pc_unit: RTL and testbench



---
 rtl/ir_pc_unit_pkg.sv | 15 +
 rtl/ir_pc_unit_if.sv | 28 ++
 rtl/ir_pc_unit_load_reg.sv | 20 ++
 rtl/ir_pc_unit.sv | 50 +++++
 tb/tb_ir_pc_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/ir_pc_unit_pkg.sv
// Shared widths, field positions and types for the instruction-fetch datapath
// of the 8-bit accumulator processor.
package ir_pc_unit_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int OP_W   = DATA_W - ADDR_W;

   // Opcode occupies the bits above the address field
   localparam int OP_MSB = DATA_W - 1;
   localparam int OP_LSB = ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [OP_W-1:0]   opcode_t;
endpackage

// File: rtl/ir_pc_unit_if.sv
// Strobe/data bundle between the controller (master) and the IR/PC datapath (slave).
interface ir_pc_unit_if;
   import ir_pc_unit_pkg::*;

   word_t   Q_ram;
   logic    IRload;
   logic    PCload;
   logic    JMPmux;
   logic    Meminst;

   word_t   Q_IR;
   addr_t   Q_IRmux;
   opcode_t IR;
   addr_t   D_PC;
   addr_t   Q_Incr;
   addr_t   Q_PC;
   addr_t   Q_Meminst;

   modport master (
      output Q_ram, IRload, PCload, JMPmux, Meminst,
      input  Q_IR, Q_IRmux, IR, D_PC, Q_Incr, Q_PC, Q_Meminst
   );

   modport slave (
      input  Q_ram, IRload, PCload, JMPmux, Meminst,
      output Q_IR, Q_IRmux, IR, D_PC, Q_Incr, Q_PC, Q_Meminst
   );
endinterface

// File: rtl/ir_pc_unit_load_reg.sv
// Loadable register with synchronous active-high clear; clear beats load.
module ir_pc_unit_load_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock) begin
      if (Reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ir_pc_unit.sv
// Instruction register, program counter with incrementer/jump mux, and the
// fetch/operand memory-address mux.
module ir_pc_unit
   import ir_pc_unit_pkg::*;
(
   input  logic         clock,
   input  logic         Reset,
   ir_pc_unit_if.slave  bus
);

   word_t   q_ir;
   addr_t   q_pc;
   addr_t   ir_addr;
   opcode_t ir_op;
   addr_t   pc_incr;
   addr_t   pc_next;
   addr_t   mem_addr;

   ir_pc_unit_load_reg #(.WIDTH(DATA_W)) u_ir_reg (
      .clock (clock),
      .Reset (Reset),
      .load  (bus.IRload),
      .d     (bus.Q_ram),
      .q     (q_ir)
   );

   // PC loads from the jump mux, which sees the IR value from before this edge
   ir_pc_unit_load_reg #(.WIDTH(ADDR_W)) u_pc_reg (
      .clock (clock),
      .Reset (Reset),
      .load  (bus.PCload),
      .d     (pc_next),
      .q     (q_pc)
   );

   assign ir_addr  = q_ir[ADDR_W-1:0];
   assign ir_op    = q_ir[OP_MSB:OP_LSB];
   assign pc_incr  = q_pc + addr_t'(1);
   assign pc_next  = bus.JMPmux  ? ir_addr : pc_incr;
   assign mem_addr = bus.Meminst ? ir_addr : q_pc;

   assign bus.Q_IR      = q_ir;
   assign bus.Q_IRmux   = ir_addr;
   assign bus.IR        = ir_op;
   assign bus.Q_Incr    = pc_incr;
   assign bus.D_PC      = pc_next;
   assign bus.Q_PC      = q_pc;
   assign bus.Q_Meminst = mem_addr;

endmodule

// File: tb/tb_ir_pc_unit.sv
// Bench for ir_pc_unit: directed plan plus random strobes against a value model.
module tb_ir_pc_unit;
   logic clock;
   logic Reset;
   int   vectors;
   int   miscompares;

   // Model state: plain integers for the IR word and PC value
   int   m_ir;
   int   m_pc;
   bit   m_known;

   ir_pc_unit_if bus ();

   ir_pc_unit dut (
      .clock (clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      int incr;
      incr = (m_pc + 1) % 32;
      check({tag, " Q_IR"},      32'(bus.Q_IR),      32'(m_ir));
      check({tag, " IR"},        32'(bus.IR),        32'(m_ir / 32));
      check({tag, " Q_IRmux"},   32'(bus.Q_IRmux),   32'(m_ir % 32));
      check({tag, " Q_PC"},      32'(bus.Q_PC),      32'(m_pc));
      check({tag, " Q_Incr"},    32'(bus.Q_Incr),    32'(incr));
      check({tag, " D_PC"},      32'(bus.D_PC),      32'(bus.JMPmux ? m_ir % 32 : incr));
      check({tag, " Q_Meminst"}, 32'(bus.Q_Meminst), 32'(bus.Meminst ? m_ir % 32 : m_pc));
   endtask

   // Apply one clock of stimulus, check combinational outputs before the edge
   // and registered state after it.
   task automatic step(input int ram, input bit rst, input bit irl, input bit pcl,
                       input bit jmp, input bit mem, input string tag);
      int d_pc;
      Reset       = rst;
      bus.Q_ram   = 8'(ram);
      bus.IRload  = irl;
      bus.PCload  = pcl;
      bus.JMPmux  = jmp;
      bus.Meminst = mem;
      #1;
      if (m_known) check_outputs({tag, " pre"});
      d_pc = jmp ? m_ir % 32 : (m_pc + 1) % 32;
      if (rst) begin
         m_ir = 0;
         m_pc = 0;
         m_known = 1'b1;
      end else begin
         if (pcl) m_pc = d_pc;
         if (irl) m_ir = ram % 256;
      end
      @(posedge clock);
      #1;
      if (m_known) check_outputs({tag, " post"});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_ir        = 0;
      m_pc        = 0;
      m_known     = 1'b0;
      Reset       = 1'b0;
      bus.Q_ram   = '0;
      bus.IRload  = 1'b0;
      bus.PCload  = 1'b0;
      bus.JMPmux  = 1'b0;
      bus.Meminst = 1'b0;
      @(posedge clock);
      #1;

      // Reset beats pending loads
      step(8'hFF, 1, 1, 1, 0, 0, "reset");
      check("rst Q_IR", 32'(bus.Q_IR), 32'h00);
      check("rst Q_PC", 32'(bus.Q_PC), 32'h00);
      check("rst Q_Incr", 32'(bus.Q_Incr), 32'h01);
      check("rst Q_Meminst", 32'(bus.Q_Meminst), 32'h00);

      // IR load/decode
      step(8'h06, 0, 1, 0, 0, 0, "ir06");
      check("ir06 IR", 32'(bus.IR), 32'h0);
      check("ir06 Q_IRmux", 32'(bus.Q_IRmux), 32'h06);
      step(8'hCB, 0, 1, 0, 0, 0, "irCB");
      check("irCB IR", 32'(bus.IR), 32'h6);
      check("irCB Q_IRmux", 32'(bus.Q_IRmux), 32'h0B);
      step(8'h1B, 0, 1, 0, 0, 0, "ir1B");
      check("ir1B IR", 32'(bus.IR), 32'h0);
      check("ir1B Q_IRmux", 32'(bus.Q_IRmux), 32'h1B);
      step(8'h55, 0, 0, 0, 0, 0, "irhold");
      check("irhold Q_IR", 32'(bus.Q_IR), 32'h1B);

      // Sequential count through the 31 -> 0 wrap
      for (int i = 0; i < 33; i++) begin
         step(8'h55, 0, 0, 1, 0, 0, "count");
         check("count Q_PC", 32'(bus.Q_PC), 32'((i + 1) % 32));
      end

      // Jump to the IR address field
      step(8'hCB, 0, 1, 0, 0, 0, "ldCB");
      bus.JMPmux = 1'b1;
      #1;
      check("jmp D_PC", 32'(bus.D_PC), 32'h0B);
      step(8'h00, 0, 0, 1, 1, 0, "jump");
      check("jump Q_PC", 32'(bus.Q_PC), 32'h0B);
      check("jump Q_Incr", 32'(bus.Q_Incr), 32'h0C);
      step(8'h00, 0, 0, 0, 1, 0, "pchold");
      check("pchold Q_PC", 32'(bus.Q_PC), 32'h0B);

      // Address mux, then same-edge load uses the old IR for the jump
      step(8'h00, 1, 0, 0, 0, 0, "rst2");
      for (int i = 0; i < 5; i++) step(8'h00, 0, 0, 1, 0, 0, "to5");
      step(8'h1B, 0, 1, 0, 0, 0, "ld1B");
      bus.Meminst = 1'b0;
      #1;
      check("mem0 Q_Meminst", 32'(bus.Q_Meminst), 32'h05);
      bus.Meminst = 1'b1;
      #1;
      check("mem1 Q_Meminst", 32'(bus.Q_Meminst), 32'h1B);
      step(8'h03, 0, 1, 1, 1, 1, "same");
      check("same Q_PC", 32'(bus.Q_PC), 32'h1B);
      check("same Q_IR", 32'(bus.Q_IR), 32'h03);

      // Random strobes, occasional mid-run reset
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(255)), ($urandom_range(15) == 0),
              bit'($urandom_range(1)), bit'($urandom_range(1)),
              bit'($urandom_range(1)), bit'($urandom_range(1)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
